// File: rtl/spi_txn_sequencer.sv
// Request/response front-end for an SPI master: selects a slave, loads and starts
// the master, waits for the received byte (or a timeout) and returns it.
module spi_txn_sequencer #(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned CS_SETUP   = 1,
  parameter int unsigned CS_HOLD    = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_slave,
  input  logic [7:0]            req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_data,
  output logic [1:0]            rsp_slave,
  output logic                  rsp_timeout,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] cs_n,
  output logic [1:0]            miso_sel,
  output logic                  m_load,
  output logic [7:0]            m_data_in,
  output logic                  m_start,
  input  logic                  m_busy,
  input  logic                  m_done,
  input  logic [7:0]            m_data_out
);

  // One shared timer covers the setup, wait and hold phases.
  localparam int unsigned TMR_MAX =
    (TIMEOUT > CS_SETUP) ? ((TIMEOUT > CS_HOLD) ? TIMEOUT : CS_HOLD)
                         : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int unsigned TW = $clog2(TMR_MAX + 1);
  localparam logic [2:0]  NS = 3'(NUM_SLAVES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_LOAD, ST_START, ST_WAIT, ST_HOLD, ST_RESP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    data_q;

  assign req_ready = (state == ST_IDLE) && !m_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      data_q      <= '0;
      cs_n        <= '1;
      miso_sel    <= '0;
      m_load      <= 1'b0;
      m_start     <= 1'b0;
      m_data_in   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_slave   <= '0;
      rsp_timeout <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      m_load  <= 1'b0;
      m_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            data_q      <= req_data;
            rsp_slave   <= req_slave;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            timer       <= '0;
            // Out-of-range slave: answer with an error, never touch the bus.
            if ({1'b0, req_slave} >= NS) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              rsp_err  <= 1'b0;
              cs_n     <= ~(NUM_SLAVES'(1) << req_slave);
              miso_sel <= req_slave;
              state    <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (timer == TW'(CS_SETUP - 1)) begin
            timer     <= '0;
            m_load    <= 1'b1;
            m_data_in <= data_q;
            state     <= ST_LOAD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_LOAD: begin
          m_start   <= 1'b1;
          m_data_in <= '0;
          state     <= ST_START;
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done strobe on the expiry cycle takes priority over the timeout.
          if (m_done) begin
            rsp_data <= m_data_out;
            timer    <= '0;
            state    <= ST_HOLD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            timer       <= '0;
            state       <= ST_HOLD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_HOLD: begin
          if (timer == TW'(CS_HOLD - 1)) begin
            timer     <= '0;
            cs_n      <= '1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a master stub and a response scoreboard.
module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_slave = '0;
  logic [7:0] req_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [1:0] rsp_slave;
  logic       rsp_timeout;
  logic       rsp_err;
  logic [2:0] cs_n;
  logic [1:0] miso_sel;
  logic       m_load;
  logic [7:0] m_data_in;
  logic       m_start;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_data_out = '0;

  logic       stub_en = 1'b1;
  logic [7:0] stub_byte = '0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] slave;
    logic       tmo;
    logic       err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  spi_txn_sequencer #(.NUM_SLAVES(3), .CS_SETUP(1), .CS_HOLD(1), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
    .rsp_timeout(rsp_timeout), .rsp_err(rsp_err),
    .cs_n(cs_n), .miso_sel(miso_sel), .m_load(m_load), .m_data_in(m_data_in), .m_start(m_start),
    .m_busy(m_busy), .m_done(m_done), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [7:0] d, input logic [1:0] s, input logic t,
                              input logic e);
    rsp_t r;
    r.data  = d;
    r.slave = s;
    r.tmo   = t;
    r.err   = e;
    return r;
  endfunction

  // Master stub: returns stub_byte with a done strobe 9 cycles after the start strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (m_start === 1'b1 && stub_en) begin
        repeat (9) @(negedge clk);
        m_done     = 1'b1;
        m_data_out = stub_byte;
        @(negedge clk);
        m_done     = 1'b0;
      end
    end
  end

  // Bus invariants every cycle, and scoreboard compare on each response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      chk("cs_onehot", 32'($countones(~cs_n) <= 1), 1);
      chk("load_start_excl", 32'(m_load & m_start), 0);
      if (!reset && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
          chk("sb_rsp_slave", 32'(rsp_slave), 32'(e.slave));
          chk("sb_rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
          chk("sb_rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic [7:0] d, input rsp_t e);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_slave = s;
    req_data  = d;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_valid_wait", 32'(rsp_valid), 1);
  endtask

  initial begin
    int cyc;
    logic [2:0] cs_exp [3];
    logic [1:0] sl [3];
    logic [7:0] by [3];
    cs_exp = '{3'b101, 3'b011, 3'b110};
    sl     = '{2'd1, 2'd2, 2'd0};
    by     = '{8'hE4, 8'hF0, 8'h0F};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 'h7);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_m_load", 32'(m_load), 0);
    chk("rst_m_start", 32'(m_start), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single transfer with nominal timing
    stub_byte = 8'hA5;
    send(2'd0, 8'hFF, mk(8'hA5, 2'd0, 1'b0, 1'b0));
    chk("t1_cs_after_acc", 32'(cs_n), 'h6);
    chk("t1_miso_sel", 32'(miso_sel), 0);
    chk("t1_no_load_yet", 32'(m_load), 0);
    @(negedge clk);
    chk("t1_m_load", 32'(m_load), 1);
    chk("t1_m_data_in", 32'(m_data_in), 'hFF);
    chk("t1_no_start_yet", 32'(m_start), 0);
    @(negedge clk);
    chk("t1_m_start", 32'(m_start), 1);
    chk("t1_load_dropped", 32'(m_load), 0);
    wait_rsp(cyc);
    chk("t1_rsp_latency", 32'(cyc), 11);
    chk("t1_cs_released", 32'(cs_n), 'h7);
    @(negedge clk);

    // Back-to-back transfers to slaves 1, 2, 0
    for (int i = 0; i < 3; i++) begin
      stub_byte = by[i];
      send(sl[i], 8'h30 + 8'(i), mk(by[i], sl[i], 1'b0, 1'b0));
      chk("b2b_cs_n", 32'(cs_n), 32'(cs_exp[i]));
      chk("b2b_miso_sel", 32'(miso_sel), 32'(sl[i]));
      wait_rsp(cyc);
      chk("b2b_cs_deselect", 32'(cs_n), 'h7);
      @(negedge clk);
    end

    // Timeout: stub stays silent
    stub_en = 1'b0;
    send(2'd1, 8'h55, mk(8'h00, 2'd1, 1'b1, 1'b0));
    repeat (2) @(negedge clk);
    chk("tmo_m_start", 32'(m_start), 1);
    wait_rsp(cyc);
    chk("tmo_latency", 32'(cyc), 66);
    chk("tmo_cs_released", 32'(cs_n), 'h7);
    @(negedge clk);
    stub_en   = 1'b1;
    stub_byte = 8'h5A;
    send(2'd1, 8'h3C, mk(8'h5A, 2'd1, 1'b0, 1'b0));
    wait_rsp(cyc);
    @(negedge clk);

    // Out-of-range slave
    send(2'd3, 8'h77, mk(8'h00, 2'd3, 1'b0, 1'b1));
    chk("err_rsp_valid", 32'(rsp_valid), 1);
    chk("err_rsp_err", 32'(rsp_err), 1);
    chk("err_cs_n", 32'(cs_n), 'h7);
    chk("err_no_load", 32'(m_load), 0);
    chk("err_no_start", 32'(m_start), 0);
    @(negedge clk);
    chk("err_no_load_after", 32'(m_load), 0);

    // Response backpressure
    rsp_ready = 1'b0;
    stub_byte = 8'hC3;
    send(2'd2, 8'h11, mk(8'hC3, 2'd2, 1'b0, 1'b0));
    wait_rsp(cyc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_data", 32'(rsp_data), 'hC3);
      chk("bp_rsp_slave", 32'(rsp_slave), 2);
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_valid_cleared", 32'(rsp_valid), 0);
    chk("bp_req_ready_back", 32'(req_ready), 1);

    // Reset during WAIT
    stub_byte = 8'h99;
    send(2'd2, 8'h42, mk(8'h99, 2'd2, 1'b0, 1'b0));
    repeat (4) @(negedge clk);
    chk("rw_cs_before_reset", 32'(cs_n), 'h3);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rw_cs_n", 32'(cs_n), 'h7);
    chk("rw_rsp_valid", 32'(rsp_valid), 0);
    chk("rw_m_load", 32'(m_load), 0);
    chk("rw_m_start", 32'(m_start), 0);
    chk("rw_miso_sel", 32'(miso_sel), 0);
    chk("rw_m_data_in", 32'(m_data_in), 0);
    chk("rw_rsp_fields", 32'({rsp_data, rsp_slave, rsp_timeout, rsp_err}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_req_ready", 32'(req_ready), 1);
    m_busy    = 1'b1;
    req_valid = 1'b1;
    req_slave = 2'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("busy_req_ready", 32'(req_ready), 0);
      chk("busy_no_select", 32'(cs_n), 'h7);
      chk("rw_no_rsp", 32'(rsp_valid), 0);
    end
    req_valid = 1'b0;
    m_busy    = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 1);

    chk("sb_empty", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
